// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_e;

    localparam logic [2:0] RES_LOAD = 3'b001;

    // Pipeline-register hold/clear bundle.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
    } hz_ctl_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit register file tracking destinations of in-flight long-latency ops.
module reg_scoreboard #(
    parameter int unsigned NREG = 32,
    localparam int unsigned RAW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [RAW-1:0]  set_idx,
    input  logic            clr_en,
    input  logic [RAW-1:0]  clr_idx,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] busy_nxt;

    // Clear first so a same-register set in the same cycle wins; x0 never busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use and scoreboard stalls,
// memory back-pressure, branch flushes and a saturating stall counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NSRC  = 2,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned RAW  = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NSRC-1:0][RAW-1:0]  RsD,
    input  logic [RAW-1:0]            RdD,
    input  logic [NSRC-1:0][RAW-1:0]  RsE,
    input  logic [RAW-1:0]            RdE,
    input  logic [RAW-1:0]            RdM,
    input  logic [RAW-1:0]            RdW,
    input  logic [2:0]                ResultSrcE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      PCSrcE,
    input  logic                      LongIssueE,
    input  logic                      LongDone,
    input  logic [RAW-1:0]            LongRd,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [NSRC-1:0][1:0]      ForwardE,
    output logic [NREG-1:0]           BusyVec,
    output logic [CNT_W-1:0]          StallCount
);

    logic    load_stall;
    logic    sb_stall;
    logic    mem_stall;
    logic    sb_set;
    hz_ctl_t ctl;

    // Memory stage result has priority over writeback for forwarding.
    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            ForwardE[i] = FWD_NONE;
            if (RsE[i] != '0 && RegWriteM && RsE[i] == RdM) begin
                ForwardE[i] = FWD_M;
            end else if (RsE[i] != '0 && RegWriteW && RsE[i] == RdW) begin
                ForwardE[i] = FWD_W;
            end
        end
    end

    // Load-use and scoreboard (RAW on sources, WAW on destination) detection.
    always_comb begin
        load_stall = 1'b0;
        sb_stall   = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (ResultSrcE == RES_LOAD && RdE != '0 && RsD[i] == RdE) begin
                load_stall = 1'b1;
            end
            if (RsD[i] != '0 && BusyVec[RsD[i]]) begin
                sb_stall = 1'b1;
            end
        end
        if (RdD != '0 && BusyVec[RdD]) begin
            sb_stall = 1'b1;
        end
    end

    // Memory back-pressure freezes the whole pipe and defers any flush.
    always_comb begin
        mem_stall   = MemReqM & ~MemReadyM;
        ctl         = '0;
        if (mem_stall) begin
            ctl.stall_f = 1'b1;
            ctl.stall_d = 1'b1;
            ctl.stall_e = 1'b1;
            ctl.stall_m = 1'b1;
        end else begin
            ctl.stall_f = load_stall | sb_stall;
            ctl.stall_d = load_stall | sb_stall;
            ctl.flush_e = load_stall | sb_stall | PCSrcE;
            ctl.flush_d = PCSrcE;
        end
        StallF = ctl.stall_f;
        StallD = ctl.stall_d;
        StallE = ctl.stall_e;
        StallM = ctl.stall_m;
        FlushD = ctl.flush_d;
        FlushE = ctl.flush_e;
        sb_set = LongIssueE && RdE != '0 && !ctl.stall_e;
    end

    reg_scoreboard #(.NREG(NREG)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (sb_set),
        .set_idx (RdE),
        .clr_en  (LongDone),
        .clr_idx (LongRd),
        .busy    (BusyVec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
        end else if (StallF && StallCount != '1) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl with a queue-based scoreboard.
module tb_hazard_ctrl;

    localparam int unsigned NSRC  = 2;
    localparam int unsigned NREG  = 32;
    localparam int unsigned RAW   = 5;
    localparam int unsigned CNT_W = 32;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      reset;
    logic [NSRC-1:0][RAW-1:0]  RsD, RsE;
    logic [RAW-1:0]            RdD, RdE, RdM, RdW, LongRd;
    logic [2:0]                ResultSrcE;
    logic                      RegWriteM, RegWriteW, PCSrcE, LongIssueE, LongDone;
    logic                      MemReqM, MemReadyM;
    logic                      StallF, StallD, StallE, StallM, FlushD, FlushE;
    logic [NSRC-1:0][1:0]      ForwardE;
    logic [NREG-1:0]           BusyVec;
    logic [CNT_W-1:0]          StallCount;

    hazard_ctrl #(.NSRC(NSRC), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .RsD(RsD), .RdD(RdD), .RsE(RsE), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .LongIssueE(LongIssueE),
        .LongDone(LongDone), .LongRd(LongRd), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardE(ForwardE), .BusyVec(BusyVec),
        .StallCount(StallCount)
    );

    typedef struct packed {
        logic                     reset;
        logic [NSRC-1:0][RAW-1:0] rs_d;
        logic [RAW-1:0]           rd_d;
        logic [NSRC-1:0][RAW-1:0] rs_e;
        logic [RAW-1:0]           rd_e;
        logic [RAW-1:0]           rd_m;
        logic [RAW-1:0]           rd_w;
        logic [2:0]               res_src_e;
        logic                     reg_wr_m;
        logic                     reg_wr_w;
        logic                     pc_src_e;
        logic                     long_issue;
        logic                     long_done;
        logic [RAW-1:0]           long_rd;
        logic                     mem_req;
        logic                     mem_ready;
    } stim_t;

    // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE}
    typedef struct packed {
        logic [NSRC-1:0][1:0] fwd;
        logic [5:0]           ctl;
        logic [NREG-1:0]      busy;
        logic [CNT_W-1:0]     cnt;
    } exp_t;

    exp_t            expq[$];
    int              total = 0;
    int              bad   = 0;
    bit              mbusy[NREG];
    longint unsigned mcnt = 0;
    bit              model_valid = 1'b0;

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   mem, load, sb, hz;
        e    = '0;
        load = 1'b0;
        sb   = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (s.rs_e[i] != 0 && s.reg_wr_m && s.rs_e[i] == s.rd_m)      e.fwd[i] = 2'b10;
            else if (s.rs_e[i] != 0 && s.reg_wr_w && s.rs_e[i] == s.rd_w) e.fwd[i] = 2'b01;
            else                                                           e.fwd[i] = 2'b00;
            if (s.res_src_e == 3'b001 && s.rd_e != 0 && s.rs_d[i] == s.rd_e) load = 1'b1;
            if (s.rs_d[i] != 0 && mbusy[int'(s.rs_d[i])]) sb = 1'b1;
        end
        if (s.rd_d != 0 && mbusy[int'(s.rd_d)]) sb = 1'b1;
        mem = s.mem_req && !s.mem_ready;
        hz  = load || sb;
        if (mem) e.ctl = 6'b111100;
        else     e.ctl = {hz, hz, 1'b0, 1'b0, s.pc_src_e, hz || s.pc_src_e};
        for (int r = 0; r < int'(NREG); r++) e.busy[r] = mbusy[r];
        e.cnt = CNT_W'(mcnt);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        reset = s.reset; RsD = s.rs_d; RdD = s.rd_d; RsE = s.rs_e; RdE = s.rd_e;
        RdM = s.rd_m; RdW = s.rd_w; ResultSrcE = s.res_src_e; RegWriteM = s.reg_wr_m;
        RegWriteW = s.reg_wr_w; PCSrcE = s.pc_src_e; LongIssueE = s.long_issue;
        LongDone = s.long_done; LongRd = s.long_rd; MemReqM = s.mem_req; MemReadyM = s.mem_ready;
        e = predict(s);
        if (model_valid) expq.push_back(e);
        @(posedge clk);
        if (s.reset) begin
            for (int r = 0; r < int'(NREG); r++) mbusy[r] = 1'b0;
            mcnt        = 0;
            model_valid = 1'b1;
        end else begin
            if (s.long_done) mbusy[int'(s.long_rd)] = 1'b0;
            if (s.long_issue && s.rd_e != 0 && !e.ctl[3]) mbusy[int'(s.rd_e)] = 1'b1;
            mbusy[0] = 1'b0;
            if (e.ctl[5] && mcnt < CNT_MAX) mcnt++;
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("forward",    64'(ForwardE),   64'(e.fwd));
                chk("stallflush", 64'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 64'(e.ctl));
                chk("busyvec",    64'(BusyVec),    64'(e.busy));
                chk("stallcount", 64'(StallCount), 64'(e.cnt));
            end
        end
    end

    function automatic logic [RAW-1:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return RAW'($urandom_range(0, NREG - 1));
        return RAW'($urandom_range(0, 3));
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            s.rs_d[i] = rnd_reg();
            s.rs_e[i] = rnd_reg();
        end
        s.rd_d       = rnd_reg();
        s.rd_e       = rnd_reg();
        s.rd_m       = rnd_reg();
        s.rd_w       = rnd_reg();
        s.res_src_e  = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
        s.reg_wr_m   = 1'($urandom_range(0, 1));
        s.reg_wr_w   = 1'($urandom_range(0, 1));
        s.pc_src_e   = ($urandom_range(0, 5) == 0);
        s.long_issue = ($urandom_range(0, 3) == 0);
        s.long_done  = ($urandom_range(0, 3) == 0);
        s.long_rd    = rnd_reg();
        s.mem_req    = ($urandom_range(0, 3) == 0);
        s.mem_ready  = 1'($urandom_range(0, 1));
        s.reset      = ($urandom_range(0, 63) == 0);
        return s;
    endfunction

    initial begin
        stim_t s, z, rs;
        z = '0;
        rs = '0; rs.reset = 1'b1;
        apply(rs); apply(rs);

        // Forwarding priority and the x0 exclusion
        s = z; s.rs_e[0] = 5; s.rd_m = 5; s.reg_wr_m = 1; s.rd_w = 5; s.reg_wr_w = 1;
        apply(s);
        s.rs_e[0] = 0; apply(s);
        s = z; s.rs_e[1] = 6; s.rd_w = 6; s.reg_wr_w = 1; apply(s);

        // Load-use hazard, and the RdE==0 case that must not stall
        s = z; s.res_src_e = 3'b001; s.rd_e = 7; s.rs_d[1] = 7; apply(s);
        s.rd_e = 0; s.rs_d[1] = 0; apply(s);

        // Long op on x9: dependent decode waits until the cycle after LongDone
        s = z; s.long_issue = 1; s.rd_e = 9; apply(s);
        s = z; s.rs_d[0] = 9; apply(s); apply(s); apply(s);
        s.long_done = 1; s.long_rd = 9; apply(s);
        s = z; s.rs_d[0] = 9; apply(s);

        // Same-cycle clear and re-issue of x9 keeps it busy; WAW via RdD
        s = z; s.long_issue = 1; s.rd_e = 9; apply(s);
        s.long_done = 1; s.long_rd = 9; apply(s);
        s = z; s.rd_d = 9; apply(s);
        s = z; s.long_done = 1; s.long_rd = 9; apply(s);
        s = z; s.long_done = 1; s.long_rd = 4; apply(s);
        s = z; s.long_done = 1; s.long_rd = 0; s.long_issue = 1; s.rd_e = 3; apply(s);
        s = z; s.long_done = 1; s.long_rd = 3; s.long_issue = 1; s.rd_e = 0; apply(s);

        // Memory stall holds everything and defers the branch flush
        s = z; s.mem_req = 1; s.mem_ready = 0; s.pc_src_e = 1; s.long_issue = 1; s.rd_e = 12;
        apply(s); apply(s); apply(s);
        s.mem_ready = 1; s.long_issue = 0; apply(s);
        apply(z);

        // Reset mid-operation with x9 busy and a nonzero stall count
        apply(rs);
        s = z; s.long_issue = 1; s.rd_e = 9; apply(s);
        s = z; s.rs_d[0] = 9;
        repeat (12) apply(s);
        apply(rs);
        apply(z);

        for (int n = 0; n < 600; n++) apply(rnd_stim());
        apply(rs);
        apply(z);

        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
